// File: rtl/sram_arbiter_mp.sv
// N-port arbiter and asynchronous-SRAM timing engine (clk200 domain).
// Requesters use toggle req/ack handshakes. Each access runs SETUP, ACCESS
// (ACCESS_CYCLES long) and RECOVER. Arbitration also runs in RECOVER, so
// back-to-back accesses need no idle gap. An optional fixed-priority port
// always wins; the remaining ports share round-robin.
module sram_arbiter_mp #(
    parameter int NUM_PORTS     = 3,
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 3,
    parameter int HAS_PRIORITY  = 1,
    parameter int PRIORITY_PORT = 0
) (
    input  logic                        clk200,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    output logic [NUM_PORTS-1:0]        ack,
    input  logic [NUM_PORTS-1:0]        read,
    input  logic [NUM_PORTS*ADDR_W-1:0] address,
    input  logic [NUM_PORTS-1:0]        lb,
    input  logic [NUM_PORTS-1:0]        ub,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS*DATA_W-1:0] rdata,
    output logic                        SR_OE_n,
    output logic                        SR_WE_n,
    output logic                        SR_LB_n,
    output logic                        SR_UB_n,
    output logic [ADDR_W-1:0]           SR_A,
    output logic [DATA_W-1:0]           SR_D_o,
    output logic                        SR_D_oe,
    input  logic [DATA_W-1:0]           SR_D_i
);

    localparam int             PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW:0]    NP       = NUM_PORTS[PW:0];
    localparam logic [PW:0]    ONE      = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0]  PRIO     = PRIORITY_PORT[PW-1:0];
    localparam logic [3:0]     LAST     = ACCESS_CYCLES[3:0];
    localparam bit             USE_PRIO = (HAS_PRIORITY != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t               state;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        rr_ptr;
    logic [3:0]           cnt;
    logic                 is_read;

    logic [NUM_PORTS-1:0] pend;
    logic                 win_vld;
    logic [PW-1:0]        win;
    logic [PW-1:0]        win_nxt;
    logic [PW:0]          cand;
    logic [PW:0]          nxt;
    logic                 sel_read;
    logic                 sel_lb;
    logic                 sel_ub;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // Pick the next winner. In RECOVER the granted port is judged as if its
    // ack had already toggled, so only a fresh re-request from it counts.
    always_comb begin
        pend = req ^ ack;
        if (state == RECOVER) begin
            pend[grant] = ~pend[grant];
        end
        win_vld = 1'b0;
        win     = '0;
        cand    = {1'b0, rr_ptr};
        if (USE_PRIO && pend[PRIO]) begin
            win_vld = 1'b1;
            win     = PRIO;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cand >= NP) begin
                    cand = cand - NP;
                end
                if (!win_vld && pend[cand[PW-1:0]] &&
                    !(USE_PRIO && cand[PW-1:0] == PRIO)) begin
                    win_vld = 1'b1;
                    win     = cand[PW-1:0];
                end
                cand = cand + ONE;
            end
        end
        nxt = {1'b0, win} + ONE;
        if (nxt >= NP) begin
            nxt = nxt - NP;
        end
        win_nxt   = nxt[PW-1:0];
        sel_read  = read[win];
        sel_lb    = lb[win];
        sel_ub    = ub[win];
        sel_addr  = address[int'(win)*ADDR_W +: ADDR_W];
        sel_wdata = wdata[int'(win)*DATA_W +: DATA_W];
    end

    // Access sequencer: strobes, latched request fields, read capture and ack toggling.
    always_ff @(posedge clk200) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            is_read <= 1'b0;
            ack     <= '0;
            rdata   <= '0;
            SR_OE_n <= 1'b1;
            SR_WE_n <= 1'b1;
            SR_LB_n <= 1'b1;
            SR_UB_n <= 1'b1;
            SR_A    <= '0;
            SR_D_o  <= '0;
            SR_D_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    SR_LB_n <= 1'b1;
                    SR_UB_n <= 1'b1;
                end
                SETUP: begin
                    state   <= ACCESS;
                    cnt     <= 4'd1;
                    SR_OE_n <= ~is_read;
                    SR_WE_n <= is_read;
                end
                ACCESS: begin
                    if (cnt == LAST) begin
                        state   <= RECOVER;
                        SR_OE_n <= 1'b1;
                        SR_WE_n <= 1'b1;
                        if (is_read) begin
                            rdata[int'(grant)*DATA_W +: DATA_W] <= SR_D_i;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECOVER: begin
                    ack[grant] <= ~ack[grant];
                    SR_D_oe    <= 1'b0;
                    state      <= IDLE;
                    SR_LB_n    <= 1'b1;
                    SR_UB_n    <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // A grant from IDLE or RECOVER overrides the release values above.
            if ((state == IDLE || state == RECOVER) && win_vld) begin
                state   <= SETUP;
                grant   <= win;
                is_read <= sel_read;
                SR_A    <= sel_addr;
                SR_LB_n <= ~sel_lb;
                SR_UB_n <= ~sel_ub;
                SR_D_o  <= sel_wdata;
                SR_D_oe <= ~sel_read;
                if (!(USE_PRIO && win == PRIO)) begin
                    rr_ptr <= win_nxt;
                end
            end
        end
    end

endmodule
